tone_sequencer: RTL and testbench



---
 rtl/tone_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_tone_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Note player: accepts one note command at a time and drives a square-wave
// buzzer for the requested duration, followed by a fixed silence gap.
module tone_sequencer #(
  parameter int CLK_HZ = 50_000_000,
  parameter int CNT_W  = 26,
  parameter int DUR_W  = 12,
  parameter int GAP_MS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [3:0]       note_idx,
  input  logic [1:0]       octave,
  input  logic [DUR_W-1:0] dur_ms,
  input  logic             stop,
  output logic             buzz,
  output logic             busy,
  output logic             done
);

  localparam int MS_CYC = CLK_HZ / 1000;
  localparam int GAP_W  = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
  localparam int REM_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;
  localparam logic [CNT_W-1:0] MS_LAST = CNT_W'(MS_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic [CNT_W-1:0] tone_q, tone_d;
  logic [CNT_W-1:0] pres_q, pres_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             rest_q, rest_d;
  logic             buzz_q, buzz_d;
  logic             done_q, done_d;
  logic             ms_tick;

  // Octave-0 half periods in clock cycles, folded to constants at elaboration.
  function automatic logic [CNT_W-1:0] base_hp(input logic [3:0] idx);
    case (idx)
      4'd0:    base_hp = CNT_W'(CLK_HZ / 524);
      4'd1:    base_hp = CNT_W'(CLK_HZ / 588);
      4'd2:    base_hp = CNT_W'(CLK_HZ / 660);
      4'd3:    base_hp = CNT_W'(CLK_HZ / 698);
      4'd4:    base_hp = CNT_W'(CLK_HZ / 784);
      4'd5:    base_hp = CNT_W'(CLK_HZ / 880);
      4'd6:    base_hp = CNT_W'(CLK_HZ / 988);
      4'd7:    base_hp = CNT_W'(CLK_HZ / 1046);
      4'd8:    base_hp = CNT_W'(CLK_HZ / 1174);
      4'd9:    base_hp = CNT_W'(CLK_HZ / 1318);
      default: base_hp = '0;
    endcase
  endfunction

  // A zero half period (rest, or a very slow clock) is clamped to 1 so the
  // wrap compare never underflows.
  function automatic logic [CNT_W-1:0] half_period(input logic [3:0] idx,
                                                   input logic [1:0] oct);
    logic [CNT_W-1:0] hp;
    hp = base_hp(idx) >> oct;
    half_period = (hp == '0) ? CNT_W'(1) : hp;
  endfunction

  assign ms_tick    = (pres_q == MS_LAST);
  assign note_ready = (state_q == S_IDLE) && !rst;
  assign busy       = (state_q != S_IDLE);
  assign buzz       = buzz_q;
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    tone_d  = tone_q;
    pres_d  = pres_q;
    rem_d   = rem_q;
    rest_d  = rest_q;
    buzz_d  = buzz_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        buzz_d = 1'b0;
        if (note_valid) begin
          hp_d   = half_period(note_idx, octave);
          rest_d = (note_idx >= 4'd10);
          tone_d = '0;
          pres_d = '0;
          if (dur_ms == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_PLAY;
            rem_d   = REM_W'(dur_ms);
          end
        end
      end

      S_PLAY: begin
        if (stop) begin
          state_d = S_IDLE;
          buzz_d  = 1'b0;
          tone_d  = '0;
          pres_d  = '0;
          rem_d   = '0;
        end else begin
          if (tone_q == hp_q - CNT_W'(1)) begin
            tone_d = '0;
            if (!rest_q) buzz_d = ~buzz_q;
          end else begin
            tone_d = tone_q + CNT_W'(1);
          end
          pres_d = ms_tick ? '0 : pres_q + CNT_W'(1);
          if (ms_tick) begin
            rem_d = rem_q - REM_W'(1);
            // Last ms of the note: silence wins over any coincident toggle.
            if (rem_q == REM_W'(1)) begin
              buzz_d = 1'b0;
              tone_d = '0;
              pres_d = '0;
              if (GAP_MS == 0) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                rem_d   = '0;
              end else begin
                state_d = S_GAP;
                rem_d   = REM_W'(GAP_MS);
              end
            end
          end
        end
      end

      S_GAP: begin
        buzz_d = 1'b0;
        if (stop) begin
          state_d = S_IDLE;
          pres_d  = '0;
          rem_d   = '0;
        end else begin
          pres_d = ms_tick ? '0 : pres_q + CNT_W'(1);
          if (ms_tick) begin
            rem_d = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        buzz_d  = 1'b0;
        tone_d  = '0;
        pres_d  = '0;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hp_q    <= '0;
      tone_q  <= '0;
      pres_q  <= '0;
      rem_q   <= '0;
      rest_q  <= 1'b0;
      buzz_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      tone_q  <= tone_d;
      pres_q  <= pres_d;
      rem_q   <= rem_d;
      rest_q  <= rest_d;
      buzz_q  <= buzz_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: elapsed-time reference model checked every cycle,
// directed scenarios with literal timing expectations, then random commands.
module tb_tone_sequencer;

  localparam int CLK_HZ = 1_000_000;
  localparam int GAP_MS = 2;
  localparam int DUR_W  = 12;
  localparam int MS     = CLK_HZ / 1000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             note_valid = 1'b1;
  logic [3:0]       note_idx = 4'd5;
  logic [1:0]       octave = 2'd0;
  logic [DUR_W-1:0] dur_ms = 12'd5;
  logic             stop = 1'b0;
  logic             note_ready, buzz, busy, done;

  tone_sequencer #(
    .CLK_HZ(CLK_HZ), .CNT_W(26), .DUR_W(DUR_W), .GAP_MS(GAP_MS)
  ) dut (
    .clk(clk), .rst(rst), .note_valid(note_valid), .note_ready(note_ready),
    .note_idx(note_idx), .octave(octave), .dur_ms(dur_ms), .stop(stop),
    .buzz(buzz), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: a note is "active" for (dur+gap) ms counted from accept.
  bit m_act = 0, m_done = 0, m_rest = 0;
  int m_t = 0, m_hp = 1, m_dur = 0;
  bit chk_en = 0;
  int exp_buzz;

  int acc_cyc = -1, first_rise = -1, last_tog = -1;
  int tog_min = 0, tog_max = 0, done_cnt = 0, last_done = -1;
  bit prev_buzz = 0;

  function automatic int freq(input int i);
    case (i)
      0: return 262;  1: return 294;  2: return 330;  3: return 349;
      4: return 392;  5: return 440;  6: return 494;  7: return 523;
      8: return 587;  9: return 659;
      default: return 0;
    endcase
  endfunction

  function automatic int model_hp(input int i, input int o);
    int f, hp;
    f = freq(i);
    if (f == 0) return 1;
    hp = (CLK_HZ / (2 * f)) >> o;
    return (hp < 1) ? 1 : hp;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    m_done = 0;
    if (rst) begin
      m_act  = 0;
      chk_en = 1;
    end else if (!m_act) begin
      if (note_valid) begin
        acc_cyc    = cyc;
        first_rise = -1;
        last_tog   = -1;
        tog_min    = 1 << 30;
        tog_max    = 0;
        done_cnt   = 0;
        m_hp   = model_hp(int'(note_idx), int'(octave));
        m_rest = (note_idx >= 4'd10);
        m_dur  = int'(dur_ms);
        if (m_dur == 0) m_done = 1;
        else begin
          m_act = 1;
          m_t   = 0;
        end
      end
    end else if (stop) begin
      m_act = 0;
    end else begin
      m_t++;
      if (m_t == (m_dur + GAP_MS) * MS) begin
        m_act  = 0;
        m_done = 1;
      end
    end
    #1;
    if (chk_en) begin
      exp_buzz = (m_act && !m_rest && m_t < m_dur * MS) ? ((m_t / m_hp) % 2) : 0;
      chk("buzz", int'(buzz), exp_buzz);
      chk("busy", int'(busy), int'(m_act));
      chk("done", int'(done), int'(m_done));
      chk("note_ready", int'(note_ready), int'(!m_act && !rst));
      if (done) begin
        done_cnt++;
        last_done = cyc;
      end
      if (buzz != prev_buzz) begin
        if (last_tog >= 0) begin
          if (cyc - last_tog < tog_min) tog_min = cyc - last_tog;
          if (cyc - last_tog > tog_max) tog_max = cyc - last_tog;
        end
        last_tog = cyc;
        if (buzz && first_rise < 0) first_rise = cyc;
      end
      prev_buzz = buzz;
    end
  end

  task automatic send(input int i, input int o, input int d, input bit with_stop = 1'b0);
    int n;
    @(negedge clk);
    note_idx   = 4'(i);
    octave     = 2'(o);
    dur_ms     = DUR_W'(d);
    note_valid = 1'b1;
    stop       = with_stop;
    #1;
    n = 0;
    while (!note_ready && n < 20000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!note_ready) chk("accept_timeout", 0, 1);
    else @(posedge clk);
    @(negedge clk);
    note_valid = 1'b0;
    stop       = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int acc1, n, act;

    // Reset held with a pending command.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", int'(note_ready), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_buzz", int'(buzz), 0);
    rst = 1'b0;
    note_valid = 1'b0;
    #1;
    chk("ready_after_reset", int'(note_ready), 1);

    // A4, octave 0, 5 ms.
    send(5, 0, 5);
    wait_idle(8000);
    wait_cycles(3);
    chk("a4_first_rise", first_rise - acc_cyc, 1136);
    chk("a4_tog_min", tog_min, 1136);
    chk("a4_tog_max", tog_max, 1136);
    chk("a4_done_lat", last_done - acc_cyc, 7000);
    chk("a4_done_cnt", done_cnt, 1);

    // C4 two octaves up, 3 ms.
    send(0, 2, 3);
    wait_idle(6000);
    wait_cycles(3);
    chk("oct_first_rise", first_rise - acc_cyc, 477);
    chk("oct_tog_min", tog_min, 477);
    chk("oct_tog_max", tog_max, 477);
    chk("oct_done_lat", last_done - acc_cyc, 5000);

    // Rest.
    send(15, 0, 3);
    wait_idle(6000);
    wait_cycles(3);
    chk("rest_no_rise", first_rise, -1);
    chk("rest_done_lat", last_done - acc_cyc, 5000);
    chk("rest_done_cnt", done_cnt, 1);

    // Zero duration: done in the cycle right after accept.
    send(5, 0, 0);
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    wait_cycles(3);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_done_lat", last_done - acc_cyc, 0);

    // Abort mid-note.
    send(5, 0, 5);
    wait_cycles(2498);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_buzz", int'(buzz), 0);
    wait_cycles(10);
    chk("abort_no_done", done_cnt, 0);

    // stop together with a command in IDLE: command accepted.
    send(5, 0, 1, 1'b1);
    chk("stopvalid_busy", int'(busy), 1);
    wait_idle(4000);
    wait_cycles(2);
    chk("stopvalid_done_cnt", done_cnt, 1);

    // Back-to-back: second command held while the first plays.
    send(5, 0, 1);
    acc1 = acc_cyc;
    note_idx   = 4'd9;
    octave     = 2'd1;
    dur_ms     = DUR_W'(1);
    note_valid = 1'b1;
    n = 0;
    while (acc_cyc == acc1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    note_valid = 1'b0;
    chk("b2b_accept_lat", acc_cyc - acc1, 3001);
    wait_idle(4000);
    wait_cycles(3);
    chk("b2b_first_rise", first_rise - acc_cyc, 379);
    chk("b2b_tog_min", tog_min, 379);
    chk("b2b_tog_max", tog_max, 379);
    chk("b2b_done_lat", last_done - acc_cyc, 3000);

    // Random commands with random stops and resets.
    for (int k = 0; k < 10; k++) begin
      send($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 2));
      act = $urandom_range(0, 3);
      if (act == 0) begin
        wait_cycles($urandom_range(0, 2800));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
      end else if (act == 1) begin
        wait_cycles($urandom_range(0, 2800));
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
      end
      wait_idle(5000);
      wait_cycles($urandom_range(0, 3));
    end

    wait_cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
